// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// signed or unsigned, owning the HI/LO result registers.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] da,
  input  logic [WIDTH-1:0] db,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  logic [1:0]       state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] opb_q,    opb_d;
  logic [WIDTH:0]   acc_q,    acc_d;
  logic [WIDTH-1:0] work_q,   work_d;
  logic             is_div_q, is_div_d;
  logic             qneg_q,   qneg_d;
  logic             rneg_q,   rneg_d;
  logic             zero_q,   zero_d;
  logic             done_q,   done_d;
  logic             div0_q,   div0_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;

  // Operand preparation at accept time.
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;

  // The most-negative value negates to itself, which read unsigned is its magnitude.
  assign is_signed = ~op[0];
  assign a_neg     = is_signed & da[WIDTH-1];
  assign b_neg     = is_signed & db[WIDTH-1];
  assign a_mag     = a_neg ? -da : da;
  assign b_mag     = b_neg ? -db : db;
  assign b_zero    = (db == '0);

  // One iteration of each algorithm on the shared acc/work datapath.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign mul_sum   = acc_q + (work_q[0] ? {1'b0, opb_q} : '0);
  assign div_shift = {acc_q[WIDTH-1:0], work_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_diff  = div_shift - {1'b0, opb_q};

  assign prod     = {acc_q[WIDTH-1:0], work_q};
  assign prod_fix = qneg_q ? -prod : prod;
  assign quo_fix  = qneg_q ? -work_q : work_q;
  assign rem_fix  = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    work_d   = work_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (flush) begin
      // Abort wins over both a pending start and any in-flight op.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (op[2] && !op[1]) begin
              if (op[0]) lo_d = da;
              else       hi_d = da;
            end else if (!op[2]) begin
              state_d  = S_CALC;
              cnt_d    = CNT_INIT;
              is_div_d = op[1];
              zero_d   = op[1] & b_zero;
              div0_d   = 1'b0;
              acc_d    = '0;
              if (op[1] && b_zero) begin
                // Raw dividend with divisor 0 yields quotient all ones, remainder da.
                opb_d  = '0;
                work_d = da;
                qneg_d = 1'b0;
                rneg_d = 1'b0;
              end else begin
                opb_d  = b_mag;
                work_d = a_mag;
                qneg_d = a_neg ^ b_neg;
                rneg_d = a_neg;
              end
            end
          end
        end

        S_CALC: begin
          if (zero_q) div0_d = 1'b1;
          if (is_div_q) begin
            acc_d  = div_ge ? div_diff : div_shift;
            work_d = {work_q[WIDTH-2:0], div_ge};
          end else begin
            acc_d  = {1'b0, mul_sum[WIDTH:1]};
            work_d = {mul_sum[0], work_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = S_FIX;
        end

        S_FIX: begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state is only ever updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      work_q   <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      work_q   <= work_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases plus randomized ops
// compared against an arithmetic reference model (WIDTH=32 and WIDTH=8 instances).
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush;
  logic [2:0]  op;
  logic [31:0] da, db;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  logic        start8;
  logic [2:0]  op8;
  logic [7:0]  da8, db8;
  logic        busy8, done8, div08;
  logic [7:0]  hi8, lo8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .reset(rst_n), .start(start), .op(op), .da(da), .db(db), .flush(flush),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  mdu_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst_n), .start(start8), .op(op8), .da(da8), .db(db8), .flush(1'b0),
    .busy(busy8), .done(done8), .div0(div08), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on sign-extended values.
  function automatic void ref_md(input int w, input logic [2:0] o, input logic [63:0] a_in,
                                 input logic [63:0] b_in, output logic [63:0] rhi,
                                 output logic [63:0] rlo);
    logic [63:0] mask, a, b, p;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    rhi = '0;
    rlo = '0;
    case (o)
      3'b000, 3'b001: begin
        if (o == 3'b000) p = sa * sb;
        else             p = a * b;
        rhi = (p >> w) & mask;
        rlo = p & mask;
      end
      default: begin
        if (b == 0) begin
          rlo = mask;
          rhi = a;
        end else if (o == 3'b010) begin
          q = sa / sb;
          r = sa % sb;
          rlo = q & mask;
          rhi = r & mask;
        end else begin
          rlo = (a / b) & mask;
          rhi = (a % b) & mask;
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return $urandom & 32'hFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one MULT/DIV op, follow it to done and check timing and results.
  // poke_k >= 0 drives a conflicting start that many edges after accept.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int poke_k);
    logic [63:0] eh, el;
    logic        exp_z;
    int          k, busy_cnt;
    ref_md(32, o, {32'b0, a}, {32'b0, b}, eh, el);
    exp_z = o[1] && (b == 0);
    start = 1'b1; op = o; da = a; db = b;
    tick();
    start = 1'b0; op = 3'b110; da = $urandom; db = $urandom;
    check({tag, ".busy_e0"}, 64'(busy), 64'd1);
    check({tag, ".div0_e0"}, 64'(div0), 64'd0);
    k = 0;
    busy_cnt = 1;
    do begin
      if (k == poke_k) begin
        start = 1'b1; op = 3'b011; da = $urandom; db = $urandom;
      end
      tick();
      k++;
      start = 1'b0;
      if (busy) busy_cnt++;
      if (k == 1) check({tag, ".div0_e1"}, 64'(div0), 64'(exp_z));
    end while (!done && k < 100);
    check({tag, ".latency"}, 64'(k), 64'd33);
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, ".hi"}, 64'(hi), eh);
    check({tag, ".lo"}, 64'(lo), el);
    check({tag, ".div0"}, 64'(div0), 64'(exp_z));
  endtask

  initial begin
    logic [31:0] ph, pl;
    logic        d0, saw_done;
    logic [63:0] eh, el;
    int          k;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; da = '0; db = '0;
    start8 = 1'b0; op8 = '0; da8 = '0; db8 = '0;
    repeat (3) tick();
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.div0", 64'(div0), 64'd0);
    check("rst.hi", 64'(hi), 64'd0);
    check("rst.lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    tick();

    // Directed vectors (model-checked inside do_op, literal values checked here).
    do_op("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'd5, -1);
    check("mult_neg.hi_lit", 64'(hi), 64'hFFFF_FFFF);
    check("mult_neg.lo_lit", 64'(lo), 64'hFFFF_FFF1);
    do_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("multu_max.hi_lit", 64'(hi), 64'hFFFF_FFFE);
    check("multu_max.lo_lit", 64'(lo), 64'h0000_0001);
    do_op("divu_100_7", 3'b011, 32'd100, 32'd7, -1);
    check("divu_100_7.lo_lit", 64'(lo), 64'h0000_000E);
    check("divu_100_7.hi_lit", 64'(hi), 64'h0000_0002);
    do_op("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2, -1);
    check("div_m7_2.lo_lit", 64'(lo), 64'hFFFF_FFFD);
    check("div_m7_2.hi_lit", 64'(hi), 64'hFFFF_FFFF);
    do_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("div_ovf.lo_lit", 64'(lo), 64'h8000_0000);
    check("div_ovf.hi_lit", 64'(hi), 64'h0);
    do_op("divu_zero", 3'b011, 32'd1234, 32'd0, -1);
    check("divu_zero.lo_lit", 64'(lo), 64'hFFFF_FFFF);
    check("divu_zero.hi_lit", 64'(hi), 64'h0000_04D2);
    do_op("div_zero_neg", 3'b010, 32'hFFFF_FFF0, 32'd0, -1);
    check("div_zero_neg.hi_lit", 64'(hi), 64'hFFFF_FFF0);

    // Randomized ops, issued back-to-back in the done cycle.
    for (int i = 0; i < 24; i++) begin
      do_op("rand", 3'($urandom_range(0, 3)), pick(), pick(), -1);
    end

    // A start while busy is ignored.
    do_op("ignore", 3'b000, 32'h1234_5678, 32'hFEDC_BA98, 5);

    // MTHI/MTLO: immediate write, no busy, no done, div0 untouched.
    d0 = div0;
    start = 1'b1; op = 3'b101; da = 32'h0000_ABCD;
    tick();
    start = 1'b0;
    check("mtlo.lo", 64'(lo), 64'h0000_ABCD);
    check("mtlo.busy", 64'(busy), 64'd0);
    check("mtlo.done", 64'(done), 64'd0);
    check("mtlo.div0", 64'(div0), 64'(d0));
    start = 1'b1; op = 3'b100; da = 32'h5A5A_0001;
    tick();
    start = 1'b0;
    check("mthi.hi", 64'(hi), 64'h5A5A_0001);
    check("mthi.lo_kept", 64'(lo), 64'h0000_ABCD);
    check("mthi.busy", 64'(busy), 64'd0);

    // Flush mid-CALC: no done, HI/LO keep prior values.
    ph = hi; pl = lo;
    start = 1'b1; op = 3'b001; da = 32'h0BAD_F00D; db = 32'h0000_1001;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush.busy", 64'(busy), 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("flush.no_done", 64'(saw_done), 64'd0);
    check("flush.hi", 64'(hi), 64'(ph));
    check("flush.lo", 64'(lo), 64'(pl));

    // flush together with start in IDLE: nothing is accepted.
    start = 1'b1; flush = 1'b1; op = 3'b101; da = 32'h1357_9BDF;
    tick();
    check("flush_start.lo", 64'(lo), 64'(pl));
    op = 3'b000;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start.busy", 64'(busy), 64'd0);

    // Asynchronous reset mid-CALC with div0 and HI/LO non-zero.
    do_op("pre_rst", 3'b011, 32'd1234, 32'd0, -1);
    start = 1'b1; op = 3'b010; da = 32'd77; db = 32'd0;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.done", 64'(done), 64'd0);
    check("rst_mid.div0", 64'(div0), 64'd0);
    check("rst_mid.hi", 64'(hi), 64'd0);
    check("rst_mid.lo", 64'(lo), 64'd0);
    #1 rst_n = 1'b1;
    tick();

    // WIDTH=8 instance: MULT 7F*80.
    ref_md(8, 3'b000, 64'h7F, 64'h80, eh, el);
    start8 = 1'b1; op8 = 3'b000; da8 = 8'h7F; db8 = 8'h80;
    tick();
    start8 = 1'b0;
    k = 0;
    do begin
      tick();
      k++;
    end while (!done8 && k < 50);
    check("w8.latency", 64'(k), 64'd9);
    check("w8.hi", 64'(hi8), eh);
    check("w8.lo", 64'(lo8), el);
    check("w8.hi_lit", 64'(hi8), 64'hC0);
    check("w8.lo_lit", 64'(lo8), 64'h80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
